apb_gpio_bridge: RTL

APB3 slave that sits directly upstream of the 6-pin GPIO block. It holds shadow copies of the GPIO control, direction and output registers, and issues one-cycle command bytes on the GPIO's 8-bit command input. It captures the GPIO's 8-bit input-data bus for read-back, tracks input changes and raises a level interrupt. Wait states are programmable so the bridge can share the APB with the UART slave.

---
 rtl/gpio_bridge_pkg.sv | 32 +++
 rtl/gpio_in_capture.sv | 54 +++++
 rtl/apb_gpio_bridge.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/gpio_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpio_bridge_pkg
// Brief   : Register offsets, GPIO command selects and FSM states for the bridge
// Revision: 1.0
// ============================================================================
package gpio_bridge_pkg;

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_DIR  = 3'd1;
  localparam logic [2:0] REG_DOUT = 3'd2;
  localparam logic [2:0] REG_DIN  = 3'd3;
  localparam logic [2:0] REG_CHG  = 3'd4;
  localparam logic [2:0] REG_IEN  = 3'd5;

  localparam logic [1:0] SEL_CTRL = 2'b00;
  localparam logic [1:0] SEL_DIR  = 2'b01;
  localparam logic [1:0] SEL_DATA = 2'b10;
  localparam logic [1:0] SEL_NOP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [7:0] make_cmd(input logic [1:0] sel, input logic [5:0] payload);
    return {sel, payload};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_in_capture.sv
`default_nettype none
// ============================================================================
// Module  : gpio_in_capture
// Brief   : Samples GPIO input data, tracks per-pin change flags, drives irq
// Revision: 1.0
// ============================================================================
module gpio_in_capture (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_w,
  input  logic [5:0] i_wdata,
  input  logic [5:0] i_dir,
  input  logic       i_pctl,
  input  logic [5:0] i_ien,
  input  logic       i_clr_en,
  input  logic [5:0] i_clr,
  output logic [5:0] o_din,
  output logic [5:0] o_chg,
  output logic       o_irq
);

  logic [5:0] r_din;
  logic [5:0] r_chg;
  logic       r_irq;
  logic [5:0] w_new;
  logic [5:0] w_mask;
  logic [5:0] w_set;
  logic [5:0] w_clr;

  // Pins 1:0 carry UART TX/RX when pctl is set, so their activity is not a change.
  assign w_new  = i_wdata & ~i_dir;
  assign w_mask = i_pctl ? 6'b111100 : 6'b111111;
  assign w_set  = i_w ? ((w_new ^ r_din) & ~i_dir & w_mask) : 6'd0;
  assign w_clr  = i_clr_en ? i_clr : 6'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_din <= 6'd0;
      r_chg <= 6'd0;
      r_irq <= 1'b0;
    end else begin
      if (i_w) r_din <= w_new;
      // Clear is applied before set, so a fresh change survives a same-cycle W1C.
      r_chg <= (r_chg & ~w_clr) | w_set;
      r_irq <= |(r_chg & i_ien);
    end
  end

  assign o_din = r_din;
  assign o_chg = r_chg;
  assign o_irq = r_irq;

endmodule
`default_nettype wire

// File: rtl/apb_gpio_bridge.sv
`default_nettype none
// ============================================================================
// Module  : apb_gpio_bridge
// Brief   : APB3 slave holding GPIO shadow registers and issuing command bytes
// Revision: 1.0
// ============================================================================
module apb_gpio_bridge
  import gpio_bridge_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter int         WAIT_STATES = 1,
  parameter logic [7:0] IDLE_CMD    = 8'hC0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [7:0]        gpio_cmd,
  input  logic              gpio_w,
  input  logic [7:0]        gpio_wdata,
  output logic              irq
);

  localparam logic [2:0] C_WS = 3'(WAIT_STATES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        w_go;
  logic        w_wr;
  logic        w_rd;
  logic        w_err;
  logic [2:0]  w_reg;
  logic [31:0] w_rdata;
  logic        w_cmd_vld;
  logic [7:0]  w_cmd;

  logic        r_pctl;
  logic [5:0]  r_dir;
  logic [5:0]  r_dout;
  logic [5:0]  r_ien;
  logic [31:0] r_prdata;
  logic        r_pslverr;
  logic [7:0]  r_cmd;
  logic [5:0]  w_din;
  logic [5:0]  w_chg;
  logic        w_irq;
  logic        w_unused;

  assign w_reg    = PADDR[4:2];
  assign w_unused = ^{PADDR, PWDATA, gpio_wdata[7:6]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // w_go marks the edge that enters RESP; every side effect is keyed to it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_go        = 1'b0;
    case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = C_WS;
        end
      end
      WAIT: begin
        if (!PSEL) begin
          w_state_nxt = IDLE;
        end else if (PENABLE) begin
          if (r_cnt == 3'd0) begin
            w_state_nxt = RESP;
            w_go        = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_wr  = w_go && PWRITE;
  assign w_rd  = w_go && !PWRITE;
  assign w_err = (w_reg > REG_IEN);

  always_comb begin
    w_rdata = 32'd0;
    case (w_reg)
      REG_CTRL: w_rdata[0]   = r_pctl;
      REG_DIR:  w_rdata[5:0] = r_dir;
      REG_DOUT: w_rdata[5:0] = r_dout;
      REG_DIN:  w_rdata[5:0] = w_din;
      REG_CHG:  w_rdata[5:0] = w_chg;
      REG_IEN:  w_rdata[5:0] = r_ien;
      default:  w_rdata      = 32'd0;
    endcase
  end

  always_comb begin
    w_cmd_vld = 1'b0;
    w_cmd     = IDLE_CMD;
    if (w_wr) begin
      case (w_reg)
        REG_CTRL: begin
          w_cmd_vld = 1'b1;
          w_cmd     = make_cmd(SEL_CTRL, {5'd0, PWDATA[0]});
        end
        REG_DIR: begin
          w_cmd_vld = 1'b1;
          w_cmd     = make_cmd(SEL_DIR, PWDATA[5:0]);
        end
        REG_DOUT: begin
          w_cmd_vld = 1'b1;
          w_cmd     = make_cmd(SEL_DATA, PWDATA[5:0] & r_dir);
        end
        default: w_cmd_vld = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pctl    <= 1'b0;
      r_dir     <= 6'd0;
      r_dout    <= 6'd0;
      r_ien     <= 6'd0;
      r_prdata  <= 32'd0;
      r_pslverr <= 1'b0;
      r_cmd     <= IDLE_CMD;
    end else begin
      r_cmd <= w_cmd_vld ? w_cmd : IDLE_CMD;
      if (w_go) r_pslverr <= w_err;
      if (w_rd) r_prdata <= w_rdata;
      if (w_wr) begin
        case (w_reg)
          REG_CTRL: r_pctl <= PWDATA[0];
          REG_DIR:  r_dir  <= PWDATA[5:0];
          REG_DOUT: r_dout <= PWDATA[5:0];
          REG_IEN:  r_ien  <= PWDATA[5:0];
          default:  r_pctl <= r_pctl;
        endcase
      end
    end
  end

  gpio_in_capture u_capture (
    .clk      (clk),
    .rst      (rst),
    .i_w      (gpio_w),
    .i_wdata  (gpio_wdata[5:0]),
    .i_dir    (r_dir),
    .i_pctl   (r_pctl),
    .i_ien    (r_ien),
    .i_clr_en (w_wr && (w_reg == REG_CHG)),
    .i_clr    (PWDATA[5:0]),
    .o_din    (w_din),
    .o_chg    (w_chg),
    .o_irq    (w_irq)
  );

  assign PREADY   = (r_state == RESP);
  assign PSLVERR  = r_pslverr;
  assign PRDATA   = r_prdata;
  assign gpio_cmd = r_cmd;
  assign irq      = w_irq;

endmodule
`default_nettype wire
